// File: rtl/gpio_pkg.sv
// GPIO peripheral shared definitions: register offsets, bus widths, mask helpers.
package gpio_pkg;

  localparam int unsigned BUS_DW  = 32;
  localparam int unsigned BUS_AW  = 3;
  localparam int unsigned BUS_BEW = 4;

  localparam logic [BUS_AW-1:0] GPIO_IN      = 3'd0;
  localparam logic [BUS_AW-1:0] GPIO_OUT     = 3'd1;
  localparam logic [BUS_AW-1:0] GPIO_OE      = 3'd2;
  localparam logic [BUS_AW-1:0] GPIO_OUT_SET = 3'd3;
  localparam logic [BUS_AW-1:0] GPIO_OUT_CLR = 3'd4;
  localparam logic [BUS_AW-1:0] GPIO_RISE_EN = 3'd5;
  localparam logic [BUS_AW-1:0] GPIO_FALL_EN = 3'd6;
  localparam logic [BUS_AW-1:0] GPIO_STATUS  = 3'd7;

  // Expand per-byte enables into a per-bit write mask.
  function automatic logic [BUS_DW-1:0] be_mask(input logic [BUS_BEW-1:0] be);
    logic [BUS_DW-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < BUS_BEW; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

  // Ones in the low n bit positions; marks which register bits exist.
  function automatic logic [BUS_DW-1:0] pin_mask(input int unsigned n);
    logic [BUS_DW-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < BUS_DW; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/gpio_bus_if.sv
// Core data-bus port (req/gnt/rvalid) as seen by the GPIO peripheral.
interface gpio_bus_if;
  import gpio_pkg::*;

  logic                gpio_req;
  logic                gpio_sel;
  logic                gpio_write;
  logic [BUS_AW-1:0]   gpio_addr;
  logic [BUS_BEW-1:0]  gpio_be;
  logic [BUS_DW-1:0]   gpio_wdata;
  logic                gpio_gnt;
  logic                gpio_rvalid;
  logic [BUS_DW-1:0]   gpio_rdata;

  modport master (
    output gpio_req, gpio_sel, gpio_write, gpio_addr, gpio_be, gpio_wdata,
    input  gpio_gnt, gpio_rvalid, gpio_rdata
  );

  modport slave (
    input  gpio_req, gpio_sel, gpio_write, gpio_addr, gpio_be, gpio_wdata,
    output gpio_gnt, gpio_rvalid, gpio_rdata
  );
endinterface

// File: rtl/gpio_sync_edge.sv
// Pin input synchroniser with one-cycle history for rise/fall edge detection.
module gpio_sync_edge #(
  parameter int unsigned N_PINS      = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_PINS-1:0] i_pins,
  output logic [N_PINS-1:0] o_sync,
  output logic [N_PINS-1:0] o_rise,
  output logic [N_PINS-1:0] o_fall
);

  logic [SYNC_STAGES-1:0][N_PINS-1:0] r_chain;
  logic [N_PINS-1:0]                  r_prev;
  logic [N_PINS-1:0]                  w_sync;

  assign w_sync = r_chain[SYNC_STAGES-1];

  // Shift pins through the synchroniser; remember last synchronised value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_chain <= '0;
      r_prev  <= '0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_pins};
      r_prev  <= w_sync;
    end
  end

  assign o_sync = w_sync;
  assign o_rise = w_sync & ~r_prev;
  assign o_fall = ~w_sync & r_prev;

endmodule

// File: rtl/gpio_irq_ctrl.sv
// GPIO peripheral: N_PINS in/out/oe, atomic set/clear, edge interrupts with W1C status.
module gpio_irq_ctrl
  import gpio_pkg::*;
#(
  parameter int unsigned N_PINS      = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] OUT_RST     = '0
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  gpio_bus_if.slave         bus,
  input  logic [N_PINS-1:0] gpin,
  output logic [N_PINS-1:0] gpout,
  output logic [N_PINS-1:0] gpoe,
  output logic              irq
);

  localparam logic [BUS_DW-1:0] PIN_MASK = pin_mask(N_PINS);

  logic              w_acc;
  logic              w_wr;
  logic              w_rd;
  logic [BUS_DW-1:0] w_wmask;
  logic [N_PINS-1:0] w_wbits;
  logic [N_PINS-1:0] w_wkeep;
  logic [BUS_DW-1:0] w_rdata;
  logic [N_PINS-1:0] w_sync;
  logic [N_PINS-1:0] w_rise;
  logic [N_PINS-1:0] w_fall;
  logic [N_PINS-1:0] w_w1c;
  logic [N_PINS-1:0] w_status_next;
  logic              w_unused;

  logic [N_PINS-1:0] r_out;
  logic [N_PINS-1:0] r_oe;
  logic [N_PINS-1:0] r_rise_en;
  logic [N_PINS-1:0] r_fall_en;
  logic [N_PINS-1:0] r_status;
  logic              r_irq;
  logic              r_rvalid;
  logic [BUS_DW-1:0] r_rdata;

  assign w_acc   = bus.gpio_req & bus.gpio_sel;
  assign w_wr    = w_acc & bus.gpio_write;
  assign w_rd    = w_acc & ~bus.gpio_write;
  assign w_wmask = be_mask(bus.gpio_be) & PIN_MASK;
  assign w_wbits = bus.gpio_wdata[N_PINS-1:0] & w_wmask[N_PINS-1:0];
  assign w_wkeep = ~w_wmask[N_PINS-1:0];
  // Bits above N_PINS do not exist; writes to them are dropped.
  assign w_unused = ^{bus.gpio_wdata & ~PIN_MASK, w_wmask & ~PIN_MASK};

  gpio_sync_edge #(
    .N_PINS      (N_PINS),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk   (HCLK),
    .i_rst_n (HRESETn),
    .i_pins  (gpin),
    .o_sync  (w_sync),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // Read mux: register contents before any same-cycle write.
  always_comb begin
    w_rdata = '0;
    case (bus.gpio_addr)
      GPIO_IN:      w_rdata = 32'(w_sync);
      GPIO_OUT:     w_rdata = 32'(r_out);
      GPIO_OE:      w_rdata = 32'(r_oe);
      GPIO_RISE_EN: w_rdata = 32'(r_rise_en);
      GPIO_FALL_EN: w_rdata = 32'(r_fall_en);
      GPIO_STATUS:  w_rdata = 32'(r_status);
      default:      w_rdata = '0;
    endcase
  end

  // Pending-edge update: a new edge wins over a same-cycle W1C.
  always_comb begin
    w_w1c = '0;
    if (w_wr && (bus.gpio_addr == GPIO_STATUS)) w_w1c = w_wbits;
    w_status_next = (r_status & ~w_w1c) | (w_rise & r_rise_en) | (w_fall & r_fall_en);
  end

  // Register file writes with byte enables and atomic set/clear.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_out     <= OUT_RST[N_PINS-1:0];
      r_oe      <= '0;
      r_rise_en <= '0;
      r_fall_en <= '0;
    end else if (w_wr) begin
      case (bus.gpio_addr)
        GPIO_OUT:     r_out     <= (r_out & w_wkeep) | w_wbits;
        GPIO_OE:      r_oe      <= (r_oe & w_wkeep) | w_wbits;
        GPIO_OUT_SET: r_out     <= r_out | w_wbits;
        GPIO_OUT_CLR: r_out     <= r_out & ~w_wbits;
        GPIO_RISE_EN: r_rise_en <= (r_rise_en & w_wkeep) | w_wbits;
        GPIO_FALL_EN: r_fall_en <= (r_fall_en & w_wkeep) | w_wbits;
        default:      ;
      endcase
    end
  end

  // Status register and level interrupt derived from its next value.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_status <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_status <= w_status_next;
      r_irq    <= |w_status_next;
    end
  end

  // Single-cycle response for every accepted request.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_acc;
      r_rdata  <= w_rd ? w_rdata : '0;
    end
  end

  assign bus.gpio_gnt    = w_acc;
  assign bus.gpio_rvalid = r_rvalid;
  assign bus.gpio_rdata  = r_rdata;
  assign gpout           = r_out;
  assign gpoe            = r_oe;
  assign irq             = r_irq;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Bench for gpio_irq_ctrl: register-map model, directed scenarios and random traffic.
module tb_gpio_irq_ctrl;
  import gpio_pkg::*;

  localparam int S = 2;

  logic        HCLK    = 1'b0;
  logic        HRESETn = 1'b1;
  logic [15:0] gpin    = 16'h0;
  logic [15:0] gpout, gpoe;
  logic        irq;
  logic [7:0]  gpin8   = 8'h0;
  logic [7:0]  gpout8, gpoe8;
  logic        irq8;

  gpio_bus_if bus ();
  gpio_bus_if bus8 ();

  gpio_irq_ctrl #(.N_PINS(16), .SYNC_STAGES(S), .OUT_RST(32'h0)) u_dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus),
    .gpin(gpin), .gpout(gpout), .gpoe(gpoe), .irq(irq)
  );

  gpio_irq_ctrl #(.N_PINS(8), .SYNC_STAGES(S), .OUT_RST(32'h0000_005A)) u_dut8 (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus8),
    .gpin(gpin8), .gpout(gpout8), .gpoe(gpoe8), .irq(irq8)
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Behavioural model of the 16-pin instance: register array indexed by offset,
  // pin history array standing in for the synchroniser delay.
  logic [31:0] m_reg [8];
  logic [15:0] m_hist [S+1];
  logic        m_rvalid, m_irq;
  logic [31:0] m_rdata;
  logic [31:0] t_sync, t_prev, t_rd, t_bm, t_wv, t_w1c, t_ren, t_fen;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      foreach (m_reg[i]) m_reg[i] = 32'h0;
      foreach (m_hist[i]) m_hist[i] = 16'h0;
      m_rvalid = 1'b0;
      m_rdata  = 32'h0;
      m_irq    = 1'b0;
    end else begin
      t_sync = 32'(m_hist[S-1]);
      t_prev = 32'(m_hist[S]);
      t_ren  = m_reg[5];
      t_fen  = m_reg[6];
      t_rd   = 32'h0;
      t_w1c  = 32'h0;
      t_bm   = 32'h0;
      for (int b = 0; b < 4; b++) if (bus.gpio_be[b]) t_bm = t_bm | (32'hFF << (8 * b));
      t_bm = t_bm & 32'h0000_FFFF;
      t_wv = bus.gpio_wdata & t_bm;
      if (bus.gpio_req && bus.gpio_sel) begin
        if (!bus.gpio_write) begin
          if (bus.gpio_addr == 3'd0) t_rd = t_sync;
          else if (bus.gpio_addr == 3'd3 || bus.gpio_addr == 3'd4) t_rd = 32'h0;
          else t_rd = m_reg[bus.gpio_addr];
        end else begin
          case (bus.gpio_addr)
            3'd1, 3'd2, 3'd5, 3'd6:
              m_reg[bus.gpio_addr] = (m_reg[bus.gpio_addr] & ~t_bm) | t_wv;
            3'd3: m_reg[1] = m_reg[1] | t_wv;
            3'd4: m_reg[1] = m_reg[1] & ~t_wv;
            3'd7: t_w1c = t_wv;
            default: ;
          endcase
        end
      end
      m_reg[7] = (m_reg[7] & ~t_w1c) | (t_sync & ~t_prev & t_ren) | (~t_sync & t_prev & t_fen);
      m_irq    = (m_reg[7] != 32'h0);
      m_rvalid = bus.gpio_req && bus.gpio_sel;
      m_rdata  = t_rd;
      for (int i = S; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = gpin;
    end
  end

  // Compare process: outputs against the model every cycle, on the falling edge.
  always @(negedge HCLK) begin
    chk("gnt", 32'(bus.gpio_gnt), 32'(bus.gpio_req & bus.gpio_sel));
    chk("rvalid", 32'(bus.gpio_rvalid), 32'(m_rvalid));
    if (m_rvalid) chk("rdata", bus.gpio_rdata, m_rdata);
    chk("gpout", 32'(gpout), m_reg[1]);
    chk("gpoe", 32'(gpoe), m_reg[2]);
    chk("irq", 32'(irq), 32'(m_irq));
  end

  task automatic cyc();
    @(posedge HCLK);
    #2;
  endtask

  // One accepted transfer; returns rdata sampled in the response cycle.
  task automatic xfer(input logic wr, input logic [2:0] a, input logic [3:0] be,
                      input logic [31:0] wd, output logic [31:0] rd);
    bus.gpio_req = 1'b1; bus.gpio_sel = 1'b1; bus.gpio_write = wr;
    bus.gpio_addr = a; bus.gpio_be = be; bus.gpio_wdata = wd;
    cyc();
    bus.gpio_req = 1'b0; bus.gpio_sel = 1'b0;
    rd = bus.gpio_rdata;
  endtask

  task automatic xfer8(input logic wr, input logic [2:0] a, input logic [3:0] be,
                       input logic [31:0] wd, output logic [31:0] rd);
    bus8.gpio_req = 1'b1; bus8.gpio_sel = 1'b1; bus8.gpio_write = wr;
    bus8.gpio_addr = a; bus8.gpio_be = be; bus8.gpio_wdata = wd;
    cyc();
    bus8.gpio_req = 1'b0; bus8.gpio_sel = 1'b0;
    rd = bus8.gpio_rdata;
  endtask

  logic [31:0] rd;
  logic [31:0] exp_rst [8];

  initial begin
    bus.gpio_req = 0; bus.gpio_sel = 0; bus.gpio_write = 0;
    bus.gpio_addr = 0; bus.gpio_be = 0; bus.gpio_wdata = 0;
    bus8.gpio_req = 0; bus8.gpio_sel = 0; bus8.gpio_write = 0;
    bus8.gpio_addr = 0; bus8.gpio_be = 0; bus8.gpio_wdata = 0;
    gpin = 16'h5A3C;
    #1 HRESETn = 1'b0;
    #21 HRESETn = 1'b1;
    cyc();

    chk("rst_gpout", 32'(gpout), 32'h0);
    chk("rst_gpoe", 32'(gpoe), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_rvalid", 32'(bus.gpio_rvalid), 32'h0);
    chk("rst_gpout8", 32'(gpout8), 32'h5A);
    chk("rst_gpoe8", 32'(gpoe8), 32'h0);
    repeat (S + 1) cyc();

    exp_rst = '{32'h5A3C, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    for (int a = 0; a < 8; a++) begin
      xfer(1'b0, 3'(a), 4'hF, 32'h0, rd);
      chk($sformatf("rst_rd%0d", a), rd, exp_rst[a]);
    end

    // Byte-enabled OUT writes, then set/clear.
    xfer(1'b1, GPIO_OUT, 4'b0001, 32'h0000_00A5, rd);
    chk("out_b0", 32'(gpout), 32'h00A5);
    xfer(1'b1, GPIO_OUT, 4'b0010, 32'hFFFF_12FF, rd);
    chk("out_b1", 32'(gpout), 32'h12A5);
    chk("wr_rdata0", rd, 32'h0);
    xfer(1'b1, GPIO_OUT_SET, 4'hF, 32'h0000_0100, rd);
    chk("out_set", 32'(gpout), 32'h13A5);
    xfer(1'b1, GPIO_OUT_CLR, 4'hF, 32'h0000_0005, rd);
    chk("out_clr", 32'(gpout), 32'h13A0);
    xfer(1'b0, GPIO_OUT, 4'hF, 32'h0, rd);
    chk("rd_out", rd, 32'h13A0);
    xfer(1'b0, GPIO_OUT_SET, 4'hF, 32'h0, rd);
    chk("rd_set", rd, 32'h0);
    xfer(1'b1, GPIO_OE, 4'hF, 32'hFFFF_F0F0, rd);
    chk("oe", 32'(gpoe), 32'hF0F0);
    xfer(1'b0, GPIO_OE, 4'hF, 32'h0, rd);
    chk("rd_oe", rd, 32'h0000_F0F0);

    // Three back-to-back accepted reads, then a request without select.
    bus.gpio_req = 1; bus.gpio_sel = 1; bus.gpio_write = 0; bus.gpio_addr = GPIO_OUT;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("hs_gnt%0d", k), 32'(bus.gpio_gnt), 32'h1);
      @(posedge HCLK); #2;
      chk($sformatf("hs_rvalid%0d", k), 32'(bus.gpio_rvalid), 32'h1);
      chk($sformatf("hs_rdata%0d", k), bus.gpio_rdata, 32'h13A0);
    end
    bus.gpio_sel = 0;
    #1;
    chk("nosel_gnt", 32'(bus.gpio_gnt), 32'h0);
    @(posedge HCLK); #2;
    chk("nosel_rvalid", 32'(bus.gpio_rvalid), 32'h0);
    bus.gpio_req = 0;

    // Rising edge on pin 0 raises irq SYNC_STAGES+1 edges later; W1C clears it.
    gpin = 16'h0;
    repeat (S + 2) cyc();
    xfer(1'b1, GPIO_RISE_EN, 4'hF, 32'h1, rd);
    gpin[0] = 1'b1;
    repeat (S) cyc();
    chk("edge_irq_early", 32'(irq), 32'h0);
    cyc();
    chk("edge_irq", 32'(irq), 32'h1);
    xfer(1'b0, GPIO_STATUS, 4'hF, 32'h0, rd);
    chk("edge_status", rd, 32'h1);
    xfer(1'b1, GPIO_STATUS, 4'hF, 32'h1, rd);
    chk("w1c_irq", 32'(irq), 32'h0);
    xfer(1'b0, GPIO_STATUS, 4'hF, 32'h0, rd);
    chk("w1c_status", rd, 32'h0);

    // Falling edge on pin 3 lands in the same cycle as W1C of bit 3.
    xfer(1'b1, GPIO_RISE_EN, 4'hF, 32'h0, rd);
    xfer(1'b1, GPIO_FALL_EN, 4'hF, 32'h8, rd);
    gpin[3] = 1'b1;
    repeat (S + 2) cyc();
    chk("rise_off_irq", 32'(irq), 32'h0);
    gpin[3] = 1'b0;
    repeat (S + 2) cyc();
    chk("fall_irq", 32'(irq), 32'h1);
    gpin[3] = 1'b1;
    repeat (S + 2) cyc();
    gpin[3] = 1'b0;
    repeat (S) cyc();
    xfer(1'b1, GPIO_STATUS, 4'hF, 32'h8, rd);
    chk("coll_irq", 32'(irq), 32'h1);
    xfer(1'b0, GPIO_STATUS, 4'hF, 32'h0, rd);
    chk("coll_status", rd, 32'h8);
    xfer(1'b1, GPIO_FALL_EN, 4'hF, 32'h0, rd);
    xfer(1'b0, GPIO_STATUS, 4'hF, 32'h0, rd);
    chk("dis_keeps_status", rd, 32'h8);
    chk("dis_keeps_irq", 32'(irq), 32'h1);

    // Reset asserted during the accepted cycle of a read.
    bus.gpio_req = 1; bus.gpio_sel = 1; bus.gpio_write = 0; bus.gpio_addr = GPIO_STATUS;
    #2 HRESETn = 1'b0;
    @(posedge HCLK); #2;
    chk("rstmid_rvalid", 32'(bus.gpio_rvalid), 32'h0);
    chk("rstmid_gpout", 32'(gpout), 32'h0);
    chk("rstmid_gpoe", 32'(gpoe), 32'h0);
    chk("rstmid_irq", 32'(irq), 32'h0);
    chk("rstmid_gpout8", 32'(gpout8), 32'h5A);
    bus.gpio_req = 0; bus.gpio_sel = 0;
    #1 HRESETn = 1'b1;
    cyc();
    chk("rstmid_after_rvalid", 32'(bus.gpio_rvalid), 32'h0);

    // Narrow build: bits above N_PINS read zero and are not stored.
    xfer8(1'b1, GPIO_OUT, 4'hF, 32'h0000_FFFF, rd);
    chk("n8_gpout", 32'(gpout8), 32'hFF);
    xfer8(1'b0, GPIO_OUT, 4'hF, 32'h0, rd);
    chk("n8_rd_out", rd, 32'h0000_00FF);
    xfer8(1'b1, GPIO_OE, 4'hF, 32'hFFFF_FFFF, rd);
    chk("n8_gpoe", 32'(gpoe8), 32'hFF);
    chk("n8_irq", 32'(irq8), 32'h0);

    // Random traffic checked by the model.
    for (int i = 0; i < 600; i++) begin
      bus.gpio_req   = ($urandom_range(0, 3) != 0);
      bus.gpio_sel   = ($urandom_range(0, 3) != 0);
      bus.gpio_write = $urandom_range(0, 1);
      bus.gpio_addr  = 3'($urandom_range(0, 7));
      bus.gpio_be    = 4'($urandom);
      bus.gpio_wdata = $urandom;
      if ($urandom_range(0, 4) == 0) gpin = gpin ^ (16'h1 << $urandom_range(0, 15));
      cyc();
    end
    bus.gpio_req = 0; bus.gpio_sel = 0;
    repeat (4) cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
